// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debounce, run/pause/lap FSM and count-tick prescaler.
// Build option: STOPWATCH_AUTO_WRAP_EN lets the counter roll 99->00 instead of pausing.
module stopwatch_dbnc #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          lvl;
    logic          prv;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            lvl <= 1'b0;
            prv <= 1'b0;
            cnt <= '0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            prv <= lvl;
            if (s2 != lvl) begin
                if (cnt == CW'(DB_CYCLES - 1)) begin
                    lvl <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = lvl & ~prv;
endmodule

module stopwatch_ctrl #(
    parameter int TICK_DIV  = 25000000,
    parameter int DB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       cnt_max,
    output logic       tick_en,
    output logic       cnt_clr,
    output logic       disp_freeze,
    output logic [1:0] state
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    state_t        st;
    state_t        st_nxt;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nxt;
    logic          p_start;
    logic          p_lap;
    logic          p_clr;
    logic          wrap;
    logic          term;

    stopwatch_dbnc #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_start),
        .press (p_start)
    );

    stopwatch_dbnc #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_lap),
        .press (p_lap)
    );

    stopwatch_dbnc #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_clear),
        .press (p_clr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st  <= IDLE;
            pre <= '0;
        end else begin
            st  <= st_nxt;
            pre <= pre_nxt;
        end
    end

    always_comb begin
        st_nxt  = st;
        pre_nxt = pre;
        wrap    = ((st == RUN) || (st == LAP)) &&
                  (pre == PW'(TICK_DIV - 1));
`ifdef STOPWATCH_AUTO_WRAP_EN
        term    = 1'b0 & cnt_max;
`else
        term    = wrap & cnt_max;
`endif
        tick_en = wrap & ~term & ~p_clr;
        cnt_clr = p_clr;

        unique case (st)
            IDLE:     pre_nxt = '0;
            RUN, LAP: pre_nxt = wrap ? '0 : pre + 1'b1;
            default:  pre_nxt = pre;
        endcase

        // clear beats terminal count, which beats start, which beats lap
        if (p_clr) begin
            st_nxt = IDLE;
        end else if (term) begin
            st_nxt = PAUSE;
        end else if (p_start) begin
            unique case (st)
                IDLE:    st_nxt = RUN;
                RUN:     st_nxt = PAUSE;
                PAUSE:   st_nxt = RUN;
                default: st_nxt = PAUSE;
            endcase
        end else if (p_lap) begin
            if (st == RUN) begin
                st_nxt = LAP;
            end else if (st == LAP) begin
                st_nxt = RUN;
            end
        end
    end

    assign disp_freeze = (st == LAP);
    assign state       = st;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a cycle-level behavioural model.
// Directed test-plan scenarios first, then random button/cnt_max traffic.
module tb_stopwatch_ctrl;
    localparam int TD = 6;
    localparam int DB = 4;
`ifdef STOPWATCH_AUTO_WRAP_EN
    localparam bit AW = 1'b1;
`else
    localparam bit AW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clear = 1'b0;
    logic       cnt_max = 1'b0;
    logic       tick_en;
    logic       cnt_clr;
    logic       disp_freeze;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // model: 0 start, 1 lap, 2 clear
    int m_st;
    int m_pre;
    int diff_run [3];
    bit lvl [3];
    bit lvl_old [3];
    bit seen1 [3];
    bit seen2 [3];

    stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_start   (btn_start),
        .btn_lap     (btn_lap),
        .btn_clear   (btn_clear),
        .cnt_max     (cnt_max),
        .tick_en     (tick_en),
        .cnt_clr     (cnt_clr),
        .disp_freeze (disp_freeze),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st  = 0;
        m_pre = 0;
        for (int i = 0; i < 3; i++) begin
            diff_run[i] = 0;
            lvl[i]      = 1'b0;
            lvl_old[i]  = 1'b0;
            seen1[i]    = 1'b0;
            seen2[i]    = 1'b0;
        end
    endfunction

    function automatic bit pressed(int i);
        return lvl[i] && !lvl_old[i];
    endfunction

    function automatic bit at_wrap();
        return (m_st == 1 || m_st == 3) && (m_pre == TD - 1);
    endfunction

    function automatic bit terminal();
        return at_wrap() && cnt_max && !AW;
    endfunction

    function automatic void model_step(bit [2:0] raw);
        int nst;
        nst = m_st;
        if (pressed(2)) nst = 0;
        else if (terminal()) nst = 2;
        else if (pressed(0)) nst = (m_st == 0 || m_st == 2) ? 1 : 2;
        else if (pressed(1) && m_st == 1) nst = 3;
        else if (pressed(1) && m_st == 3) nst = 1;
        if (m_st == 0) m_pre = 0;
        else if (m_st != 2) m_pre = (m_pre + 1) % TD;
        m_st = nst;
        for (int i = 0; i < 3; i++) begin
            lvl_old[i] = lvl[i];
            if (seen2[i] != lvl[i]) begin
                diff_run[i]++;
                if (diff_run[i] == DB) begin
                    lvl[i]      = seen2[i];
                    diff_run[i] = 0;
                end
            end else begin
                diff_run[i] = 0;
            end
            seen2[i] = seen1[i];
            seen1[i] = raw[i];
        end
    endfunction

    task automatic compare_all();
        bit clr_e;
        clr_e = pressed(2);
        chk("state", state, m_st);
        chk("disp_freeze", disp_freeze, (m_st == 3));
        chk("cnt_clr", cnt_clr, clr_e);
        chk("tick_en", tick_en, at_wrap() && !terminal() && !clr_e);
    endtask

    task automatic cycle(bit [2:0] raw, bit cm);
        @(negedge clk);
        {btn_clear, btn_lap, btn_start} = raw;
        cnt_max = cm;
        #1;
        compare_all();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step(raw);
    endtask

    task automatic hold(bit [2:0] raw, int n, bit cm);
        for (int k = 0; k < n; k++) cycle(raw, cm);
    endtask

    task automatic async_reset_pulse(string tag);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk({tag, "_state"}, state, 0);
        chk({tag, "_freeze"}, disp_freeze, 0);
        chk({tag, "_tick"}, tick_en, 0);
        chk({tag, "_clr"}, cnt_clr, 0);
        cycle(3'b000, 1'b0);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        int dur [3];
        bit [2:0] raw;
        bit cm;
        model_reset();
        hold(3'b000, 3, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        hold(3'b001, 10, 1'b0);
        chk("tp1_run", state, 1);
        hold(3'b000, 20, 1'b0);

        hold(3'b001, 3, 1'b0);
        hold(3'b000, 10, 1'b0);
        chk("tp2_glitch", state, 1);
        hold(3'b001, 6, 1'b0);
        hold(3'b000, 10, 1'b0);
        chk("tp2_pause", state, 2);
        hold(3'b000, 9, 1'b0);
        hold(3'b001, 6, 1'b0);
        hold(3'b000, 10, 1'b0);
        chk("tp2_resume", state, 1);

        hold(3'b010, 6, 1'b0);
        hold(3'b000, 8, 1'b0);
        chk("tp3_lap", state, 3);
        chk("tp3_freeze", disp_freeze, 1);
        hold(3'b000, 12, 1'b0);
        hold(3'b010, 6, 1'b0);
        hold(3'b000, 8, 1'b0);
        chk("tp3_unlap", state, 1);

        hold(3'b101, 6, 1'b0);
        hold(3'b000, 8, 1'b0);
        chk("tp4_clear", state, 0);

        hold(3'b001, 6, 1'b0);
        hold(3'b000, 8, 1'b0);
        hold(3'b000, 12, 1'b1);
        chk("tp5_term", state, AW ? 1 : 2);

        hold(3'b100, 6, 1'b0);
        hold(3'b000, 8, 1'b0);
        hold(3'b001, 6, 1'b0);
        hold(3'b000, 8, 1'b0);
        hold(3'b010, 6, 1'b0);
        hold(3'b000, 9, 1'b0);
        chk("tp6_lap", state, 3);
        async_reset_pulse("tp6");
        hold(3'b000, 20, 1'b0);
        chk("tp6_idle", state, 0);

        for (int i = 0; i < 3; i++) dur[i] = 0;
        raw = 3'b000;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (dur[i] == 0) begin
                    raw[i] = ~raw[i];
                    if (raw[i]) dur[i] = $urandom_range(1, 10);
                    else if (i == 2) dur[i] = $urandom_range(30, 90);
                    else dur[i] = $urandom_range(1, 16);
                end
                dur[i]--;
            end
            cm = ($urandom_range(0, 11) == 0);
            cycle(raw, cm);
            if (c == 2500) async_reset_pulse("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
